note_player: RTL and testbench

NOTE_PLAYER -- requirements
Module: note_player

---
 rtl/note_pkg.sv | 27 ++
 rtl/note_player_tone_gen.sv | 35 +++
 rtl/note_player.sv | 111 +++++++++++
 tb/tb_note_player.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/note_pkg.sv
// note_pkg -- shared constants for the note player.
//   NOTE_W   : width of a note code (8 notes, C4..C5)
//   DEPTH    : number of note slots in the player memory
//   CNT_W    : width of the tone half-period down-counter
//   HALF     : half-period table in 50 MHz clock cycles, indexed by note code
//   scaled_half() : table lookup divided by the simulation speed-up factor
package note_pkg;

    localparam int NOTE_W = 3;
    localparam int DEPTH  = 16;
    localparam int CNT_W  = 17;

    localparam logic [CNT_W-1:0] HALF [8] = '{
        17'd95556, 17'd85131, 17'd75843, 17'd71586,
        17'd63776, 17'd56818, 17'd50619, 17'd47778
    };

    // A quotient of zero would make the reload value underflow, so clamp to 1.
    function automatic logic [CNT_W-1:0] scaled_half(input logic [NOTE_W-1:0] code,
                                                     input int                scale);
        logic [CNT_W-1:0] q;
        q = CNT_W'(int'(HALF[code]) / scale);
        if (q == '0) q = CNT_W'(1);
        return q;
    endfunction

endpackage

// File: rtl/note_player_tone_gen.sv
// tone_gen -- square-wave generator driven by a half-period down-counter.
//   clk, reset   : system clock, asynchronous active-high reset
//   enable       : when low the counter sits at its reload value and wave is 0
//   restart      : reload the counter and clear wave (new note selected)
//   half_period  : half-period in clock cycles (counter reloads to this minus 1)
//   wave         : registered square-wave output
module tone_gen
    import note_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             restart,
    input  logic [CNT_W-1:0] half_period,
    output logic             wave
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
            wave  <= 1'b0;
        end else if (restart || !enable) begin
            r_cnt <= half_period - 1'b1;
            wave  <= 1'b0;
        end else if (r_cnt == '0) begin
            r_cnt <= half_period - 1'b1;
            wave  <= ~wave;
        end else begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/note_player.sv
// note_player -- 16-slot note memory with a square-wave tone player.
//   clk, reset    : 50 MHz system clock, asynchronous active-high reset
//   ld_note       : load phase; its rising edge stores note_in and advances wr_ptr
//   ld_play       : playback phase; selects slot note_counter for playing
//   note_counter  : slot index to play
//   note_in       : note code to store (0=C4 .. 7=C5)
//   audio_out     : square-wave tone
//   cur_note      : note code of the selected slot (1-cycle latency)
//   playing       : high while a stored, non-rest slot is sounding
//   note_count    : number of stored notes, saturating at 16
// Build option: define NOTE_REST_EN to treat note code 0 as a rest.
module note_player
    import note_pkg::*;
#(
    parameter int CLK_DIV_SCALE = 1
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              ld_note,
    input  logic              ld_play,
    input  logic [3:0]        note_counter,
    input  logic [NOTE_W-1:0] note_in,
    output logic              audio_out,
    output logic [NOTE_W-1:0] cur_note,
    output logic              playing,
    output logic [4:0]        note_count
);

    logic [NOTE_W-1:0] r_mem [DEPTH];
    logic [3:0]        r_wr_ptr;
    logic [4:0]        r_note_count;
    logic [NOTE_W-1:0] r_cur_note;
    logic [3:0]        r_slot;
    logic              r_rest;
    logic              r_ld_note_d;
    logic              r_ld_play_d;

    logic              w_wr;
    logic              w_sel;
    logic              w_code_rest;
    logic              w_rest_next;
    logic              w_gate;
    logic              w_wave;
    logic [CNT_W-1:0]  w_half;
    logic [NOTE_W-1:0] w_rd;

    assign w_rd = r_mem[note_counter];
    assign w_wr = ld_note && !r_ld_note_d;

    // A slot is (re)selected when playback starts or the presented index
    // differs from the latched one. Only then is the note memory sampled, so
    // a later write into the sounding slot cannot change its tone.
    assign w_sel = ld_play && (!r_ld_play_d || (note_counter != r_slot));

`ifdef NOTE_REST_EN
    assign w_code_rest = (w_rd == '0);
`else
    assign w_code_rest = 1'b0;
`endif

    assign w_rest_next = ({1'b0, note_counter} >= r_note_count) || w_code_rest;

    // On a selection the generator reloads with the incoming note's period
    // so the new tone starts from a clean half-period on the next cycle.
    assign w_half = scaled_half(w_sel ? w_rd : r_cur_note, CLK_DIV_SCALE);

    assign w_gate = ld_play && r_ld_play_d && !ld_note && !r_rest;

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= note_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr     <= '0;
            r_note_count <= '0;
            r_cur_note   <= '0;
            r_slot       <= '0;
            r_rest       <= 1'b0;
            r_ld_note_d  <= 1'b0;
            r_ld_play_d  <= 1'b0;
        end else begin
            r_ld_note_d <= ld_note;
            r_ld_play_d <= ld_play;
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (r_note_count != 5'd16) r_note_count <= r_note_count + 1'b1;
            end
            if (w_sel) begin
                r_cur_note <= w_rd;
                r_slot     <= note_counter;
                r_rest     <= w_rest_next;
            end
        end
    end

    tone_gen u_tone (
        .clk         (clk),
        .reset       (reset),
        .enable      (ld_play && !ld_note && !r_rest),
        .restart     (w_sel),
        .half_period (w_half),
        .wave        (w_wave)
    );

    assign audio_out  = w_wave && w_gate;
    assign playing    = w_gate;
    assign cur_note   = r_cur_note;
    assign note_count = r_note_count;

endmodule

// File: tb/tb_note_player.sv
module tb_note_player;

    localparam int SCALE = 1000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       ld_note = 1'b0;
    logic       ld_play = 1'b0;
    logic [3:0] note_counter = '0;
    logic [2:0] note_in = '0;
    logic       audio_out;
    logic [2:0] cur_note;
    logic       playing;
    logic [4:0] note_count;

    int checks = 0;
    int errors = 0;

    // Reference model: plain storage plus the published half-period table.
    logic [2:0] m_mem [16];
    int         m_wp  = 0;
    int         m_cnt = 0;
    int         hv [8] = '{95556, 85131, 75843, 71586, 63776, 56818, 50619, 47778};

    note_player #(.CLK_DIV_SCALE(SCALE)) dut (
        .clk          (clk),
        .reset        (reset),
        .ld_note      (ld_note),
        .ld_play      (ld_play),
        .note_counter (note_counter),
        .note_in      (note_in),
        .audio_out    (audio_out),
        .cur_note     (cur_note),
        .playing      (playing),
        .note_count   (note_count)
    );

    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_write(input logic [2:0] v);
        m_mem[m_wp] = v;
        m_wp = (m_wp + 1) % 16;
        if (m_cnt < 16) m_cnt++;
    endtask

    task automatic load(input logic [2:0] v);
        note_in = v;
        ld_note = 1'b1;
        tick();
        ld_note = 1'b0;
        tick();
        model_write(v);
    endtask

    function automatic bit sounds(input int k);
`ifdef NOTE_REST_EN
        return (k < m_cnt) && (m_mem[k] != 3'd0);
`else
        return (k < m_cnt);
`endif
    endfunction

    // Select slot k (optionally restarting playback first), then check the
    // selected note, the playing flag and two successive half-periods.
    task automatic play(input int k, input bit drop);
        int n;
        int h;
        bit seen;
        if (drop) begin
            ld_play = 1'b0;
            tick();
            check("idle_audio", audio_out, 1'b0);
        end
        ld_play = 1'b1;
        note_counter = 4'(k);
        tick();
        if (k < m_cnt) check($sformatf("cur_note_s%0d", k), cur_note, m_mem[k]);
        check($sformatf("playing_s%0d", k), playing, sounds(k));
        check($sformatf("audio_start_s%0d", k), audio_out, 1'b0);
        if (sounds(k)) begin
            h = hv[m_mem[k]] / SCALE;
            n = 0;
            while (audio_out !== 1'b1 && n < 300) begin tick(); n++; end
            check($sformatf("half1_s%0d", k), n, h);
            n = 0;
            while (audio_out !== 1'b0 && n < 300) begin tick(); n++; end
            check($sformatf("half2_s%0d", k), n, h);
        end else begin
            seen = 1'b0;
            for (int i = 0; i < 150; i++) begin
                tick();
                if (audio_out !== 1'b0 || playing !== 1'b0) seen = 1'b1;
            end
            check($sformatf("rest_silent_s%0d", k), seen, 1'b0);
        end
    endtask

    initial begin
        int n;
        logic [2:0] v;
        logic [2:0] last;

        // Reset state
        reset = 1'b1;
        tick();
        check("rst_audio", audio_out, 1'b0);
        check("rst_playing", playing, 1'b0);
        check("rst_cur_note", cur_note, 3'd0);
        check("rst_count", note_count, 5'd0);
        check("rst_wr_ptr", dut.r_wr_ptr, 4'd0);
        reset = 1'b0;
        tick();

        // Three loads 5,0,7
        load(3'd5); load(3'd0); load(3'd7);
        check("count3", note_count, 5'd3);
        check("wp3", dut.r_wr_ptr, 4'd3);
        for (int i = 0; i < 3; i++) check($sformatf("mem%0d", i), dut.r_mem[i], m_mem[i]);

        // ld_note held 20 cycles -> one write
        note_in = 3'd2;
        ld_note = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        ld_note = 1'b0;
        tick();
        model_write(3'd2);
        check("hold_count", note_count, 5'd4);
        check("hold_wp", dut.r_wr_ptr, 4'd4);

        // Playback of stored slots, rest slot, direct slot change
        for (int k = 0; k < 4; k++) play(k, 1'b1);
        load(3'd4);
        check("count5", note_count, 5'd5);
        play(2, 1'b1);
        play(4, 1'b0);
        play(9, 1'b1);

        // Load while playing: silenced at once, write still happens
        play(0, 1'b1);
        note_in = 3'd6;
        ld_note = 1'b1;
        #1;
        check("both_playing", playing, 1'b0);
        check("both_audio", audio_out, 1'b0);
        tick();
        ld_note = 1'b0;
        model_write(3'd6);
        check("both_count", note_count, 5'(m_cnt));
        check("both_mem", dut.r_mem[5], 3'd6);

        // Reset mid-tone
        play(1, 1'b1);
        n = 0;
        while (audio_out !== 1'b1 && n < 300) begin tick(); n++; end
        check("pre_rst_high", audio_out, 1'b1);
        #2 reset = 1'b1;
        #1;
        check("midrst_audio", audio_out, 1'b0);
        check("midrst_playing", playing, 1'b0);
        check("midrst_count", note_count, 5'd0);
        ld_play = 1'b0;
        tick();
        reset = 1'b0;
        m_wp = 0;
        m_cnt = 0;
        for (int i = 0; i < 6; i++) check($sformatf("kept_mem%0d", i), dut.r_mem[i], m_mem[i]);

        // 17 random loads after reset: wrap and saturation
        last = '0;
        for (int i = 0; i < 17; i++) begin
            v = 3'($urandom_range(0, 7));
            load(v);
            last = v;
        end
        check("sat_count", note_count, 5'd16);
        check("wrap_wp", dut.r_wr_ptr, 4'd1);
        check("wrap_model_mem0", m_mem[0], last);
        play(0, 1'b1);

        // Random playback of stored slots
        for (int i = 0; i < 6; i++) play(int'($urandom_range(0, 15)), (i % 2) == 0);
        ld_play = 1'b0;
        tick();
        check("end_audio", audio_out, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
